// File: rtl/avalon_obi_pkg.sv
// Shared types and helpers for the ibex req/gnt/rvalid to Avalon-MM bridge.
// Holds the Avalon response encoding and the byte-to-word address shift.
package avalon_obi_pkg;

  typedef enum logic [1:0] {
    OKAY        = 2'b00,
    RESERVED    = 2'b01,
    SLVERR      = 2'b10,
    DECODEERROR = 2'b11
  } avm_resp_e;

  // Number of low address bits dropped when converting a byte address to a word address.
  function automatic int unsigned word_shift(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/avalon_obi_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rdata while not empty.
// Push when full and pop when empty are ignored.
module avalon_obi_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  logic [PtrW:0]    wr_ptr_r;
  logic [PtrW:0]    rd_ptr_r;
  logic [Width-1:0] mem_r [Depth];
  logic             push_ok_s;
  logic             pop_ok_s;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign full      = (wr_ptr_r[PtrW] != rd_ptr_r[PtrW]) &&
                     (wr_ptr_r[PtrW-1:0] == rd_ptr_r[PtrW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r[PtrW-1:0]];

  // Pointer update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PtrOne;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PtrOne;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Storage array, no reset needed since the pointers qualify every read.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[PtrW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/avalon_obi_bridge.sv
// Bridge from the ibex req/gnt/rvalid memory port to a pipelined Avalon-MM master,
// with up to MaxOutstanding in-flight transactions retired strictly in issue order.
module avalon_obi_bridge
  import avalon_obi_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned WordAddr       = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                data_req_i,
  input  logic                                data_we_i,
  input  logic [DataWidth/8-1:0]              data_be_i,
  input  logic [AddrWidth-1:0]                data_addr_i,
  input  logic [DataWidth-1:0]                data_wdata_i,
  output logic                                data_gnt_o,
  output logic                                data_rvalid_o,
  output logic [DataWidth-1:0]                data_rdata_o,
  output logic                                data_err_o,
  output logic [AddrWidth-1:0]                avm_address,
  output logic [DataWidth/8-1:0]              avm_byteenable,
  output logic                                avm_read,
  output logic                                avm_write,
  output logic [DataWidth-1:0]                avm_writedata,
  input  logic                                avm_waitrequest,
  input  logic [DataWidth-1:0]                avm_readdata,
  input  logic                                avm_readdatavalid,
  input  logic [1:0]                          avm_response,
  output logic [$clog2(MaxOutstanding):0]     outstanding_o
);

  localparam int unsigned CntW      = $clog2(MaxOutstanding) + 1;
  localparam int unsigned ByteShift = word_shift(DataWidth);
  localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0]    cnt_r;
  logic [CntW-1:0]    rd_pend_r;
  logic               room_s;
  logic               accept_s;
  logic               rd_accept_s;
  logic               rdv_take_s;
  logic               rdv_err_s;

  logic               order_push_s;
  logic               order_pop_s;
  logic [0:0]         order_head_s;
  logic               order_full_s;
  logic               order_empty_s;

  logic               rd_push_s;
  logic               rd_pop_s;
  logic [DataWidth:0] rd_head_s;
  logic               rd_full_s;
  logic               rd_empty_s;

  logic               retire_wr_s;
  logic               retire_rd_s;
  logic               retire_s;
  logic               rd_bypass_s;
  logic [DataWidth:0] rd_sel_s;

  // Request side is a straight pass-through gated only by the in-flight limit.
  assign room_s         = (cnt_r < CntMax) & ~order_full_s;
  assign avm_read       = data_req_i & ~data_we_i & room_s;
  assign avm_write      = data_req_i & data_we_i & room_s;
  assign avm_address    = (WordAddr != 0) ? (data_addr_i >> ByteShift) : data_addr_i;
  assign avm_byteenable = data_be_i;
  assign avm_writedata  = data_wdata_i;
  assign accept_s       = data_req_i & room_s & ~avm_waitrequest;
  assign data_gnt_o     = accept_s;
  assign rd_accept_s    = accept_s & ~data_we_i;

  // Readdatavalid with no read pending is stale traffic from before a reset.
  assign rdv_take_s = avm_readdatavalid & (rd_pend_r != '0);
  assign rdv_err_s  = (avm_resp_e'(avm_response) != OKAY);

  // Retire selection; writes and freshly arriving read data bypass their FIFOs.
  always_comb begin
    retire_wr_s = 1'b0;
    retire_rd_s = 1'b0;
    rd_bypass_s = 1'b0;
    if (order_empty_s) begin
      retire_wr_s = accept_s & data_we_i;
    end else if (order_head_s == 1'b1) begin
      retire_wr_s = 1'b1;
    end else begin
      retire_rd_s = ~rd_empty_s | rdv_take_s;
      rd_bypass_s = rd_empty_s & rdv_take_s;
    end
  end

  assign retire_s     = retire_wr_s | retire_rd_s;
  assign order_push_s = accept_s & ~(order_empty_s & data_we_i);
  assign order_pop_s  = retire_s & ~order_empty_s;
  assign rd_push_s    = rdv_take_s & ~rd_bypass_s & ~rd_full_s;
  assign rd_pop_s     = retire_rd_s & ~rd_empty_s;
  assign rd_sel_s     = rd_empty_s ? {rdv_err_s, avm_readdata} : rd_head_s;

  avalon_obi_fifo #(
    .Width (1),
    .Depth (MaxOutstanding)
  ) u_order_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (order_push_s),
    .pop    (order_pop_s),
    .wdata  (data_we_i),
    .rdata  (order_head_s),
    .full   (order_full_s),
    .empty  (order_empty_s)
  );

  avalon_obi_fifo #(
    .Width (DataWidth + 1),
    .Depth (MaxOutstanding)
  ) u_rdata_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (rd_push_s),
    .pop    (rd_pop_s),
    .wdata  ({rdv_err_s, avm_readdata}),
    .rdata  (rd_head_s),
    .full   (rd_full_s),
    .empty  (rd_empty_s)
  );

  // In-flight and pending-read counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r     <= '0;
      rd_pend_r <= '0;
    end else begin
      if (accept_s && !retire_s) begin
        cnt_r <= cnt_r + CntOne;
      end else if (!accept_s && retire_s) begin
        cnt_r <= cnt_r - CntOne;
      end else begin
        cnt_r <= cnt_r;
      end
      if (rd_accept_s && !rdv_take_s) begin
        rd_pend_r <= rd_pend_r + CntOne;
      end else if (!rd_accept_s && rdv_take_s) begin
        rd_pend_r <= rd_pend_r - CntOne;
      end else begin
        rd_pend_r <= rd_pend_r;
      end
    end
  end

  // Registered response toward the core.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
      data_rdata_o  <= '0;
    end else begin
      data_rvalid_o <= retire_s;
      if (retire_rd_s) begin
        data_err_o   <= rd_sel_s[DataWidth];
        data_rdata_o <= rd_sel_s[DataWidth-1:0];
      end else begin
        data_err_o   <= 1'b0;
        data_rdata_o <= '0;
      end
    end
  end

  assign outstanding_o = cnt_r;

endmodule

// File: tb/tb_avalon_obi_bridge.sv
// Directed bench for avalon_obi_bridge: a behavioural Avalon slave with fixed latency,
// and an in-order scoreboard of expected core responses filled at grant time.
module tb_avalon_obi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [1:0]  avm_response;
  logic [2:0]  outstanding_o;

  avalon_obi_bridge #(
    .AddrWidth      (32),
    .DataWidth      (32),
    .MaxOutstanding (4),
    .WordAddr       (1)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .data_req_i        (data_req_i),
    .data_we_i         (data_we_i),
    .data_be_i         (data_be_i),
    .data_addr_i       (data_addr_i),
    .data_wdata_i      (data_wdata_i),
    .data_gnt_o        (data_gnt_o),
    .data_rvalid_o     (data_rvalid_o),
    .data_rdata_o      (data_rdata_o),
    .data_err_o        (data_err_o),
    .avm_address       (avm_address),
    .avm_byteenable    (avm_byteenable),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_response      (avm_response),
    .outstanding_o     (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        is_rd;
    logic [32:0] exp;
  } sb_t;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  resp;
  } sp_t;

  sb_t        sb[$];
  sp_t        spipe[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         lat = 3;
  int         gnt_cnt = 0;
  int         retired = 0;
  logic [1:0] slave_resp = 2'b00;
  logic       chk_lat = 1'b0;
  logic       rdv_prev = 1'b0;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the response at negedge, record grants, then drive the slave.
  task automatic step();
    sb_t e;
    sp_t s;
    @(negedge clk_i);
    if (sb.size() == 0) begin
      check("spurious_rvalid", 64'(data_rvalid_o), 64'd0);
    end else if (data_rvalid_o === 1'b1) begin
      e = sb.pop_front();
      retired++;
      check("rsp_data", 64'({data_err_o, data_rdata_o}), 64'(e.exp));
      if (chk_lat && e.is_rd) begin
        check("rd_latency", 64'(rdv_prev), 64'd1);
      end
    end
    rdv_prev = avm_readdatavalid;
    if (data_gnt_o === 1'b1) begin
      gnt_cnt++;
      e.is_rd = ~data_we_i;
      if (data_we_i) e.exp = 33'd0;
      else e.exp = {(slave_resp != 2'b00), rd_model(data_addr_i >> 2)};
      sb.push_back(e);
    end
    if (avm_read === 1'b1 && avm_waitrequest === 1'b0) begin
      s.due  = cyc + lat;
      s.data = rd_model(avm_address);
      s.resp = slave_resp;
      spipe.push_back(s);
    end
    @(posedge clk_i);
    #1;
    cyc++;
    if (spipe.size() != 0 && spipe[0].due == cyc) begin
      s = spipe.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata      = s.data;
      avm_response      = s.resp;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'd0;
      avm_response      = 2'b00;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int r0;
    int g0;
    int n;
    rst_ni = 1'b0;
    data_req_i = 1'b0;
    data_we_i = 1'b0;
    data_be_i = 4'h0;
    data_addr_i = 32'd0;
    data_wdata_i = 32'd0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'd0;
    avm_readdatavalid = 1'b0;
    avm_response = 2'b00;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_rvalid", 64'(data_rvalid_o), 64'd0);
    check("rst_err", 64'(data_err_o), 64'd0);
    check("rst_rdata", 64'(data_rdata_o), 64'd0);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_avm_read", 64'(avm_read), 64'd0);
    check("rst_avm_write", 64'(avm_write), 64'd0);
    check("rst_gnt", 64'(data_gnt_o), 64'd0);
    rst_ni = 1'b1;
    step();

    // Single write, word address conversion, rvalid one cycle later
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h100;
    data_be_i = 4'hF; data_wdata_i = 32'hDEAD_BEEF;
    #1;
    check("wr_address", 64'(avm_address), 64'h40);
    check("wr_gnt", 64'(data_gnt_o), 64'd1);
    check("wr_avm_write", 64'(avm_write), 64'd1);
    check("wr_avm_read", 64'(avm_read), 64'd0);
    check("wr_writedata", 64'(avm_writedata), 64'hDEAD_BEEF);
    check("wr_be", 64'(avm_byteenable), 64'hF);
    r0 = retired;
    step();
    data_req_i = 1'b0; data_we_i = 1'b0;
    check("wr_outstanding", 64'(outstanding_o), 64'd0);
    step();
    check("wr_retire_n1", 64'(retired - r0), 64'd1);
    drain(10);

    // Back-to-back reads with slave latency 3
    chk_lat = 1'b1;
    g0 = gnt_cnt;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      data_addr_i = 32'(i * 4);
      step();
    end
    data_req_i = 1'b0;
    check("b2b_gnts", 64'(gnt_cnt - g0), 64'd4);
    drain(40);
    chk_lat = 1'b0;

    // Mixed read/write/read ordering and count profile
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h200;
    step();
    check("mix_out1", 64'(outstanding_o), 64'd1);
    data_we_i = 1'b1; data_addr_i = 32'h204; data_wdata_i = 32'h1234_5678;
    step();
    check("mix_out2", 64'(outstanding_o), 64'd2);
    data_we_i = 1'b0; data_addr_i = 32'h208;
    step();
    check("mix_out3", 64'(outstanding_o), 64'd3);
    data_req_i = 1'b0;
    step();
    check("mix_down2", 64'(outstanding_o), 64'd2);
    step();
    check("mix_down1", 64'(outstanding_o), 64'd1);
    step();
    check("mix_down0", 64'(outstanding_o), 64'd0);
    drain(20);

    // Backpressure: waitrequest high for 5 cycles
    avm_waitrequest = 1'b1;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h20; data_be_i = 4'h3;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_gnt", 64'(data_gnt_o), 64'd0);
      check("bp_address", 64'(avm_address), 64'h8);
      check("bp_be", 64'(avm_byteenable), 64'h3);
      check("bp_read", 64'(avm_read), 64'd1);
      step();
    end
    avm_waitrequest = 1'b0;
    #1;
    check("bp_release_gnt", 64'(data_gnt_o), 64'd1);
    step();
    data_req_i = 1'b0; data_be_i = 4'hF;
    drain(20);

    // Full: four long-latency reads, the fifth waits until the cycle after a retire
    lat = 20;
    data_req_i = 1'b1; data_we_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_addr_i = 32'h300 + 32'(i * 4);
      step();
    end
    data_addr_i = 32'h310;
    #1;
    check("full_outstanding", 64'(outstanding_o), 64'd4);
    check("full_read", 64'(avm_read), 64'd0);
    n = 0;
    while (avm_readdatavalid !== 1'b1 && n < 40) begin
      check("full_gnt", 64'(data_gnt_o), 64'd0);
      step();
      n++;
    end
    check("full_rdv_seen", 64'(avm_readdatavalid), 64'd1);
    check("full_gnt_retire_cycle", 64'(data_gnt_o), 64'd0);
    step();
    check("full_reopen_out", 64'(outstanding_o), 64'd3);
    check("full_reopen_gnt", 64'(data_gnt_o), 64'd1);
    step();
    data_req_i = 1'b0;
    drain(80);
    lat = 3;

    // Error response on a read
    slave_resp = 2'b10;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h400;
    step();
    data_req_i = 1'b0;
    slave_resp = 2'b00;
    drain(20);

    // Reset with two reads in flight; stale readdatavalid must be dropped
    lat = 6;
    data_req_i = 1'b1; data_addr_i = 32'h500;
    step();
    data_addr_i = 32'h504;
    step();
    data_req_i = 1'b0;
    step();
    check("rst_mid_out_before", 64'(outstanding_o), 64'd2);
    rst_ni = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_out_async", 64'(outstanding_o), 64'd0);
    step();
    step();
    rst_ni = 1'b1;
    check("rst_mid_rvalid", 64'(data_rvalid_o), 64'd0);
    check("rst_mid_out", 64'(outstanding_o), 64'd0);
    repeat (6) step();
    check("rst_stale_out", 64'(outstanding_o), 64'd0);
    lat = 3;
    data_req_i = 1'b1; data_addr_i = 32'h508;
    step();
    data_req_i = 1'b0;
    drain(20);
    check("final_outstanding", 64'(outstanding_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avalon_obi_bridge.md
# avalon_obi_bridge

Parametrised bridge from the ibex req/gnt/rvalid memory port to a pipelined Avalon-MM master. It supports up to `MaxOutstanding` in-flight transactions, configurable address/data width and optional byte-to-word address conversion. Writes and reads are retired to the core strictly in issue order. It replaces the single-outstanding main/instr translators and serves both the instruction and data ports (instruction use ties `data_we_i` low).

## Interface
- `AddrWidth`, 32, address width on both sides.
- `DataWidth`, 32, data width; must be 32 or 64; byte-enable width is `DataWidth/8`.
- `MaxOutstanding`, 4, maximum accepted-but-unretired transactions; power of two, at least 2.
- `WordAddr`, 1, when 1, `avm_address` = `data_addr_i` shifted right by log2(`DataWidth/8`) with zero fill; when 0, the address passes through unchanged.

Ports. One clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `data_req_i`  in  1  core request.
- `data_we_i`  in  1  1 = write.
- `data_be_i`  in  DataWidth/8  byte enables.
- `data_addr_i`  in  AddrWidth  byte address.
- `data_wdata_i`  in  DataWidth  write data.
- `data_gnt_o`  out  1  request accepted this cycle.
- `data_rvalid_o`  out  1  response valid (registered).
- `data_rdata_o`  out  DataWidth  read data (registered).
- `data_err_o`  out  1  error response (registered).
- `avm_address`  out  AddrWidth  Avalon address.
- `avm_byteenable`  out  DataWidth/8  Avalon byte enables.
- `avm_read`  out  1  Avalon read.
- `avm_write`  out  1  Avalon write.
- `avm_writedata`  out  DataWidth  Avalon write data.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  DataWidth  read data.
- `avm_readdatavalid`  in  1  read data valid.
- `avm_response`  in  2  Avalon response code.
- `outstanding_o`  out  $clog2(MaxOutstanding)+1  current in-flight count (registered).

## Operation
- Request side is combinational pass-through.
  - `room` = count < `MaxOutstanding`.
  - `avm_read` = req & ~we & room; `avm_write` = req & we & room.
  - Address, byteenable and writedata are driven from the core inputs.
  - `data_gnt_o` = req & room & ~`avm_waitrequest`.
- On accept, push the tag (`is_write`) into the order FIFO. For a read, increment the read counter `rd_pend`.
- On `avm_readdatavalid` with `rd_pend` > 0, push {err, readdata} into the read-data FIFO and decrement `rd_pend`.
  - err = (`avm_response` != OKAY).
  - With `rd_pend` == 0, readdatavalid is dropped silently (stale data after a reset).
- Retire stage, at most one transaction per cycle:
  - Head tag is write: pop the tag; next cycle `data_rvalid_o`=1, `data_err_o`=0, `data_rdata_o`=0.
  - Head tag is read and the read-data FIFO is non-empty: pop both; next cycle `data_rvalid_o`=1 with the stored data and err.
  - Otherwise: `data_rvalid_o`=0 next cycle.
- Count: +1 on accept, −1 on retire; both in the same cycle leave it unchanged.
- The read-data FIFO cannot overflow, because the number of in-flight reads is at most `MaxOutstanding`.

## Timing
- Reset: all FIFOs empty; `rd_pend`=0; count=0.
  - `data_rvalid_o`, `data_err_o`, `data_rdata_o`, `outstanding_o` = 0.
  - Combinational outputs follow their inputs. With `data_req_i`=0, `avm_read`, `avm_write` and `data_gnt_o` are 0.
- Grant latency is 0 cycles: `data_gnt_o` is asserted in the same cycle as the Avalon accept.
- Write retire: accepted at cycle N, with an empty order FIFO → `data_rvalid_o` at N+1.
- Read retire: readdatavalid at cycle M, read at head → `data_rvalid_o` at M+1.
- Sustained throughput is one accept and one retire per cycle.
- Full (count == `MaxOutstanding`): no Avalon command, no grant, even if a retire happens in the same cycle. The next cycle reopens.
- Reset mid-operation discards all in-flight state, and no rvalid is issued for the discarded transactions.

## Structure
- Package `avalon_obi_pkg`:
  - Response enum: OKAY=2'b00, RESERVED=2'b01, SLVERR=2'b10, DECODEERROR=2'b11.
  - Helper function for the word-address shift.
- Sub-module `avalon_obi_fifo`: synchronous FIFO with parameters Width and Depth.
  - Ports: push/pop/data/full/empty.
  - Reset: async active-low, empty.
  - Instantiated twice: order FIFO (Width 1) and read-data FIFO (Width DataWidth+1).

## Test plan
- Single write: addr 0x100, be 4'hF, wdata 0xDEADBEEF, waitrequest 0.
  - `avm_address`=0x40 and gnt at N; rvalid=1, err=0 at N+1.
- Back-to-back reads: 4 reads to 0x0/0x4/0x8/0xC, slave latency 3.
  - 4 gnts on consecutive cycles.
  - rvalid with data D0..D3 in order, each one cycle after its readdatavalid.
- Mixed order: read A, write B, read C.
  - Write B's rvalid appears only after A's data, and before C's.
  - `outstanding_o` steps 1,2,3, then down to 0.
- Backpressure and full: waitrequest high for 5 cycles.
  - No gnt; Avalon address/byteenable held stable.
  - With `MaxOutstanding`=4 and no readdatavalid, the 5th request sees gnt=0 and avm_read=0.
- Error: `avm_response`=2'b10 on a read → `data_err_o`=1 with `data_rdata_o`=readdata.
- Reset mid-flight: 2 reads outstanding, assert `rst_ni`=0, release, then a stale readdatavalid arrives.
  - No rvalid; `outstanding_o`=0.
  - A subsequent read retires normally.
